// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with mux selects.
// Optional retired-instruction counter enabled by defining PROC_CTRL_INSTR_CNT_EN.
module proc_ctrl_fsm #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic                    ZERO,
  input  logic                    MEM_READY,
  output logic [5:0]              STATE,
  output logic                    BUSY,
  output logic                    IR_LOAD,
  output logic                    MEM_READ,
  output logic                    MEM_WRITE,
  output logic                    RF_WRITE,
  output logic                    PC_LOAD,
  output logic                    OP2_SEL,
  output logic                    WB_SEL,
  output logic                    PC_SEL,
  output logic                    ERR
`ifdef PROC_CTRL_INSTR_CNT_EN
  ,
  output logic [31:0]             INSTR_CNT
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  // Last wait cycle index; a miss here is the MEM_TIMEOUT-th miss.
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_WIDTH-1:0] OpR   = OPCODE_WIDTH'(8'h00);
  localparam logic [OPCODE_WIDTH-1:0] OpLw  = OPCODE_WIDTH'(8'h23);
  localparam logic [OPCODE_WIDTH-1:0] OpSw  = OPCODE_WIDTH'(8'h2B);
  localparam logic [OPCODE_WIDTH-1:0] OpBeq = OPCODE_WIDTH'(8'h04);
  localparam logic [OPCODE_WIDTH-1:0] OpJmp = OPCODE_WIDTH'(8'h02);

  typedef enum logic [5:0] {
    StIdle      = 6'b000001,
    StFetch     = 6'b000010,
    StDecode    = 6'b000100,
    StExecute   = 6'b001000,
    StMemory    = 6'b010000,
    StWriteback = 6'b100000
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsJmp
  } cls_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    err_q, err_d;
  cls_e                    cls;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    cls = ClsI;
    case (opcode_q)
      OpR:     cls = ClsR;
      OpLw:    cls = ClsLw;
      OpSw:    cls = ClsSw;
      OpBeq:   cls = ClsBeq;
      OpJmp:   cls = ClsJmp;
      default: cls = ClsI;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    IR_LOAD   = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    RF_WRITE  = 1'b0;
    PC_LOAD   = 1'b0;
    OP2_SEL   = 1'b0;
    WB_SEL    = 1'b0;
    PC_SEL    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StFetch;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        MEM_READ = 1'b1;
        if (MEM_READY) begin
          IR_LOAD = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        opcode_d = OPCODE;
        state_d  = StExecute;
      end
      StExecute: begin
        OP2_SEL = (cls == ClsI) || (cls == ClsLw) || (cls == ClsSw);
        if ((cls == ClsLw) || (cls == ClsSw)) begin
          state_d = StMemory;
          cnt_d   = '0;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        MEM_READ  = (cls == ClsLw);
        MEM_WRITE = (cls == ClsSw);
        OP2_SEL   = 1'b1;
        if (MEM_READY) begin
          state_d = StWriteback;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWriteback: begin
        PC_LOAD  = 1'b1;
        RF_WRITE = (cls == ClsR) || (cls == ClsI) || (cls == ClsLw);
        WB_SEL   = (cls == ClsLw);
        PC_SEL   = (cls == ClsJmp) || ((cls == ClsBeq) && ZERO);
        if (STOP) begin
          state_d = StIdle;
        end else begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign STATE = state_q;
  assign BUSY  = (state_q != StIdle);
  assign ERR   = err_q;

`ifdef PROC_CTRL_INSTR_CNT_EN
  logic [31:0] instr_cnt_q;

  // WRITEBACK always lasts one cycle, so every WRITEBACK cycle is an exit edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      instr_cnt_q <= '0;
    end else if (state_q == StWriteback) begin
      instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign INSTR_CNT = instr_cnt_q;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: expected per-cycle state/outputs queued at drive time.
module tb_proc_ctrl_fsm;

  localparam logic [5:0] SIdle = 6'b000001;
  localparam logic [5:0] SF    = 6'b000010;
  localparam logic [5:0] SD    = 6'b000100;
  localparam logic [5:0] SE    = 6'b001000;
  localparam logic [5:0] SM    = 6'b010000;
  localparam logic [5:0] SW    = 6'b100000;

  // {BUSY, IR_LOAD, MEM_READ, MEM_WRITE, RF_WRITE, PC_LOAD, OP2_SEL, WB_SEL, PC_SEL, ERR}
  localparam logic [9:0] OB   = 10'h200;
  localparam logic [9:0] OIrl = 10'h100;
  localparam logic [9:0] OMrd = 10'h080;
  localparam logic [9:0] OMwr = 10'h040;
  localparam logic [9:0] ORfw = 10'h020;
  localparam logic [9:0] OPcl = 10'h010;
  localparam logic [9:0] OOp2 = 10'h008;
  localparam logic [9:0] OWbs = 10'h004;
  localparam logic [9:0] OPcs = 10'h002;
  localparam logic [9:0] OErr = 10'h001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] state;
  logic       busy, ir_load, mem_read, mem_write, rf_write, pc_load, op2_sel, wb_sel, pc_sel, err;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  proc_ctrl_fsm #(
    .OPCODE_WIDTH(6),
    .MEM_TIMEOUT (15)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .STOP     (stop),
    .OPCODE   (opcode),
    .ZERO     (zero),
    .MEM_READY(mem_ready),
    .STATE    (state),
    .BUSY     (busy),
    .IR_LOAD  (ir_load),
    .MEM_READ (mem_read),
    .MEM_WRITE(mem_write),
    .RF_WRITE (rf_write),
    .PC_LOAD  (pc_load),
    .OP2_SEL  (op2_sel),
    .WB_SEL   (wb_sel),
    .PC_SEL   (pc_sel),
    .ERR      (err)
`ifdef PROC_CTRL_INSTR_CNT_EN
    ,
    .INSTR_CNT(instr_cnt)
`endif
  );

`ifndef PROC_CTRL_INSTR_CNT_EN
  assign instr_cnt = '0;
`endif

  typedef struct {
    string       tag;
    logic [5:0]  st;
    logic [9:0]  outs;
    int unsigned cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned wb_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic cyc(input string tag, input logic r, input logic s, input logic p,
                     input logic [5:0] opc, input logic z, input logic rdy,
                     input logic [5:0] es, input logic [9:0] eo);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; start = s; stop = p; opcode = opc; zero = z; mem_ready = rdy;
    e.tag = tag; e.st = es; e.outs = eo; e.cnt = wb_seen;
    exp_q.push_back(e);
    if (!r) wb_seen = 0;
    else if (es == SW) wb_seen++;
  endtask

  // One instruction starting in FETCH; START/STOP pulsed mid-flight to show they are ignored.
  task automatic instr(input string tag, input logic [5:0] opc, input logic z, input int wf,
                       input int wm, input logic mem, input logic [9:0] eo_exec,
                       input logic [9:0] eo_mem, input logic [9:0] eo_wb, input logic p);
    for (int i = 0; i < wf; i++) cyc({tag, "_fwait"}, 1, 0, 0, opc, 0, 0, SF, OB | OMrd);
    cyc({tag, "_fetch"}, 1, 1, 0, opc, 0, 1, SF, OB | OMrd | OIrl);
    cyc({tag, "_dec"}, 1, 0, 0, opc, 0, 0, SD, OB);
    cyc({tag, "_exec"}, 1, 1, 1, opc, 0, 0, SE, eo_exec);
    if (mem) begin
      for (int i = 0; i < wm; i++) cyc({tag, "_mwait"}, 1, 0, 0, opc, 0, 0, SM, eo_mem);
      cyc({tag, "_mem"}, 1, 0, 0, opc, 0, 1, SM, eo_mem);
    end
    cyc({tag, "_wb"}, 1, 0, p, opc, z, 0, SW, eo_wb);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq({e.tag, "_state"}, {26'd0, state}, {26'd0, e.st});
        check_eq({e.tag, "_outs"},
                 {22'd0, busy, ir_load, mem_read, mem_write, rf_write, pc_load, op2_sel,
                  wb_sel, pc_sel, err}, {22'd0, e.outs});
`ifdef PROC_CTRL_INSTR_CNT_EN
        check_eq({e.tag, "_icnt"}, instr_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    cyc("rst0", 0, 0, 0, 6'h00, 0, 0, SIdle, '0);
    cyc("rst1", 0, 1, 1, 6'h00, 0, 1, SIdle, '0);
    for (int i = 0; i < 3; i++) cyc("idle_hold", 1, 0, 1, 6'h00, 1, 1, SIdle, '0);

    cyc("go_r", 1, 1, 0, 6'h00, 0, 1, SIdle, '0);
    instr("rtype", 6'h00, 1, 0, 0, 0, OB, '0, OB | ORfw | OPcl, 1);
    cyc("go_lw", 1, 1, 0, 6'h23, 0, 1, SIdle, '0);
    instr("lw", 6'h23, 0, 0, 3, 1, OB | OOp2, OB | OMrd | OOp2, OB | ORfw | OPcl | OWbs, 1);
    cyc("go_beq", 1, 1, 0, 6'h04, 0, 1, SIdle, '0);
    instr("beq_z1", 6'h04, 1, 0, 0, 0, OB, '0, OB | OPcl | OPcs, 0);
    instr("beq_z0", 6'h04, 0, 0, 0, 0, OB, '0, OB | OPcl, 0);
    instr("jmp", 6'h02, 0, 0, 0, 0, OB, '0, OB | OPcl | OPcs, 0);
    instr("itype", 6'h08, 1, 14, 0, 0, OB | OOp2, '0, OB | ORfw | OPcl, 0);
    instr("sw", 6'h2B, 0, 5, 14, 1, OB | OOp2, OB | OMwr | OOp2, OB | OPcl, 1);
    cyc("idle_after", 1, 0, 0, 6'h00, 0, 0, SIdle, '0);

    cyc("go_to", 1, 1, 0, 6'h00, 0, 0, SIdle, '0);
    for (int i = 0; i < 15; i++) cyc("to_wait", 1, 0, 0, 6'h00, 0, 0, SF, OB | OMrd);
    cyc("to_err", 1, 0, 0, 6'h00, 0, 0, SIdle, OErr);
    cyc("to_clr", 1, 1, 0, 6'h00, 0, 0, SIdle, OErr);
    cyc("to_fetch", 1, 0, 0, 6'h2B, 0, 1, SF, OB | OMrd | OIrl);
    cyc("rsw_dec", 1, 0, 0, 6'h2B, 0, 0, SD, OB);
    cyc("rsw_exec", 1, 0, 0, 6'h2B, 0, 0, SE, OB | OOp2);
    cyc("rsw_mwait", 1, 0, 0, 6'h2B, 0, 0, SM, OB | OMwr | OOp2);
    cyc("rsw_mwait", 1, 0, 0, 6'h2B, 0, 0, SM, OB | OMwr | OOp2);
    cyc("rsw_rst", 0, 0, 0, 6'h2B, 0, 1, SM, OB | OMwr | OOp2);
    cyc("rsw_idle", 1, 0, 0, 6'h2B, 0, 1, SIdle, '0);
    cyc("rsw_hold", 1, 0, 1, 6'h00, 0, 1, SIdle, '0);

    #10;
    check_eq("drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
